// File: rtl/div16s_by_8u_pkg.sv
// Shared encodings and default widths for the signed-dividend / unsigned-divisor divider.
// The multiplier in the same datapath uses the same default widths.
package div16s_by_8u_pkg;
    localparam int NW_DEF = 16;
    localparam int DW_DEF = 8;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_SIGN = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
endpackage

// File: rtl/div16s_by_8u_step.sv
// One restoring division iteration: shift in the next dividend bit, subtract the divisor if it fits.
module div16s_by_8u_step #(
    parameter int DW = 8
) (
    input  logic [DW:0]   rem_in,
    input  logic          n_bit,
    input  logic [DW-1:0] divisor,
    output logic [DW:0]   rem_out,
    output logic          q_bit
);
    // rem_in < divisor always holds, so the shifted value never exceeds DW+1 significant bits.
    logic [DW+1:0] sh;
    logic [DW:0]   diff;

    always_comb begin
        sh      = {rem_in, n_bit};
        q_bit   = (sh >= {2'b00, divisor});
        diff    = sh[DW:0] - {1'b0, divisor};
        rem_out = q_bit ? diff : sh[DW:0];
    end
endmodule

// File: rtl/div16s_by_8u.sv
// Sequential signed/unsigned divider: |dividend| is divided MSB-first with one restoring step per
// cycle, then the dividend sign is applied to both quotient and remainder.
module div16s_by_8u
    import div16s_by_8u_pkg::*;
#(
    parameter int NW = NW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NW-1:0] quotient,
    output logic [DW:0]   remainder,
    output logic          dbz
);
    localparam int CW = $clog2(NW);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [NW-1:0] nreg;     // dividend, shifted out MSB-first while quotient bits shift in
    logic [DW:0]   rem_r;
    logic [DW-1:0] dvs_r;
    logic          neg_r;
    logic [DW:0]   rem_nxt;
    logic          q_bit;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    div16s_by_8u_step #(.DW(DW)) u_step (
        .rem_in  (rem_r),
        .n_bit   (nreg[NW-1]),
        .divisor (dvs_r),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            nreg      <= '0;
            rem_r     <= '0;
            dvs_r     <= '0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    nreg  <= dividend;
                    dvs_r <= divisor;
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    // -2^(NW-1) negates to itself, which is the correct unsigned magnitude.
                    nreg  <= nreg[NW-1] ? -nreg : nreg;
                    neg_r <= nreg[NW-1];
                    rem_r <= '0;
                    cnt   <= '0;
                    if (dvs_r == '0) begin
                        quotient  <= '0;
                        remainder <= '0;
                        dbz       <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        state <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem_r <= rem_nxt;
                    nreg  <= {nreg[NW-2:0], q_bit};
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(NW-1))
                        state <= S_SIGN;
                end
                S_SIGN: begin
                    quotient  <= neg_r ? -nreg  : nreg;
                    remainder <= neg_r ? -rem_r : rem_r;
                    dbz       <= 1'b0;
                    state     <= S_DONE;
                end
                S_DONE: if (out_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div16s_by_8u.sv
// Self-checking bench: directed corner cases plus a random sweep against an integer-division model.
module tb_div16s_by_8u;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [8:0]  remainder;
    logic        dbz;

    int vectors = 0;
    int miscompares = 0;

    div16s_by_8u dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation from a negedge; return at the negedge where out_valid is first seen.
    task automatic issue(input logic [15:0] a, input logic [7:0] b, output int lat);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [15:0] a, input logic [7:0] b,
                                input int lat);
        int ai, bi, eq, er;
        ai = int'($signed(a));
        bi = int'(b);
        if (bi == 0) begin
            chk({tag, " lat"}, 32'(lat), 32'd1);
            chk({tag, " quo"}, {16'h0, quotient}, 32'h0);
            chk({tag, " rem"}, {23'h0, remainder}, 32'h0);
            chk({tag, " dbz"}, {31'h0, dbz}, 32'd1);
        end else begin
            eq = ai / bi;
            er = ai % bi;
            chk({tag, " lat"}, 32'(lat), 32'd18);
            chk({tag, " quo"}, {16'h0, quotient}, {16'h0, 16'(eq)});
            chk({tag, " rem"}, {23'h0, remainder}, {23'h0, 9'(er)});
            chk({tag, " dbz"}, {31'h0, dbz}, 32'd0);
        end
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " in_ready after"}, {31'h0, in_ready}, 32'd1);
        chk({tag, " out_valid after"}, {31'h0, out_valid}, 32'd0);
    endtask

    task automatic op(input string tag, input logic [15:0] a, input logic [7:0] b);
        int lat;
        issue(a, b, lat);
        check_result(tag, a, b, lat);
        release_result(tag);
    endtask

    initial begin
        int lat;
        logic [15:0] hq;
        logic [8:0]  hr;
        logic [15:0] ra;
        logic [7:0]  rb;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
        @(negedge clk);
        chk("reset in_ready",  {31'h0, in_ready},  32'd1);
        chk("reset out_valid", {31'h0, out_valid}, 32'd0);
        chk("reset quotient",  {16'h0, quotient},  32'h0);
        chk("reset remainder", {23'h0, remainder}, 32'h0);
        chk("reset dbz",       {31'h0, dbz},       32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        op("1000/7",     16'd1000,   8'd7);
        chk("1000/7 exact quo", {16'h0, quotient}, 32'd142);
        op("-1000/7",    -16'sd1000, 8'd7);
        op("-32768/1",   16'h8000,   8'd1);
        op("32767/255",  16'h7fff,   8'd255);
        op("1234/0",     16'd1234,   8'd0);
        op("0/5",        16'd0,      8'd5);
        op("-1/255",     16'hffff,   8'd255);

        // Backpressure: results must hold and new requests must be ignored.
        issue(-16'sd1000, 8'd7, lat);
        check_result("bp", -16'sd1000, 8'd7, lat);
        chk("bp quo exact", {16'h0, quotient}, 32'h0000ff72);
        chk("bp rem exact", {23'h0, remainder}, 32'h1fa);
        hq = quotient;
        hr = remainder;
        in_valid = 1'b1; dividend = 16'd5; divisor = 8'd2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp hold quo", {16'h0, quotient}, {16'h0, hq});
            chk("bp hold rem", {23'h0, remainder}, {23'h0, hr});
            chk("bp in_ready", {31'h0, in_ready}, 32'd0);
            chk("bp out_valid", {31'h0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        release_result("bp");

        // Reset in the middle of the division.
        in_valid = 1'b1; dividend = 16'd1000; divisor = 8'd3;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", {31'h0, out_valid}, 32'd0);
        chk("midrst in_ready",  {31'h0, in_ready},  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op("-255/255", -16'sd255, 8'd255);

        for (int n = 0; n < 300; n++) begin
            ra = 16'($urandom);
            rb = 8'($urandom_range(255, 1));
            op("rand", ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
